// File: rtl/mem_stage_pkg.sv
// Shared RV32I memory-access types: funct3 encodings, MEM-stage FSM states and
// a helper that classifies an access by size.
package rv32i_types;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        HOLD
    } mem_stage_state_t;

    typedef enum logic [1:0] {
        SIZE_B,
        SIZE_H,
        SIZE_W
    } access_size_t;

    // Unlisted funct3 codes fall back to a full-word access for both loads and stores.
    function automatic access_size_t access_size(input logic is_write, input logic [2:0] funct3);
        access_size_t size;
        size = SIZE_W;
        if (is_write) begin
            case (funct3)
                SB:      size = SIZE_B;
                SH:      size = SIZE_H;
                default: size = SIZE_W;
            endcase
        end else begin
            case (funct3)
                LB, LBU: size = SIZE_B;
                LH, LHU: size = SIZE_H;
                default: size = SIZE_W;
            endcase
        end
        return size;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the byte/half addressed by the offset and
// sign- or zero-extends it according to funct3.
module load_align
    import rv32i_types::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            LB:      result = {{24{byte_sel[7]}}, byte_sel};
            LBU:     result = {24'h0, byte_sel};
            LH:      result = {{16{half_sel[15]}}, half_sel};
            LHU:     result = {16'h0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM-stage controller: issues byte-steered loads/stores, stalls until the
// response, presents aligned load data. Optional macro: MEM_MISALIGN_TRAP_EN.
module mem_stage
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr_in,
    input  logic [31:0] rs2_in,
    input  logic        advance,
    output logic [31:0] dmem_address,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_mbe,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic [31:0] mdr_out,
    output logic        stall_out
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic        misaligned
`endif
);

    mem_stage_state_t state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [3:0]  mbe_q, mbe_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] mdr_q, mdr_d;

    logic         mem_op;
    logic         trap;
    access_size_t size;
    logic [1:0]   off_eff;
    logic [3:0]   mbe_new;
    logic [31:0]  load_result;

    load_align u_load_align (
        .rdata  (dmem_rdata),
        .offset (off_q),
        .funct3 (funct3_q),
        .result (load_result)
    );

    // Request decode: the offset is masked to the access's natural alignment.
    always_comb begin
        mem_op = valid_in && (mem_read || mem_write);
        size   = access_size(mem_write, funct3);
        case (size)
            SIZE_B: begin
                off_eff = addr_in[1:0];
                mbe_new = 4'b0001 << off_eff;
            end
            SIZE_H: begin
                off_eff = {addr_in[1], 1'b0};
                mbe_new = 4'b0011 << off_eff;
            end
            default: begin
                off_eff = 2'b00;
                mbe_new = 4'b1111;
            end
        endcase
`ifdef MEM_MISALIGN_TRAP_EN
        trap = ((size == SIZE_W) && (addr_in[1:0] != 2'b00)) ||
               ((size == SIZE_H) && addr_in[0]);
`else
        trap = 1'b0;
`endif
    end

    // NOTE: every variable gets its hold value first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        off_d    = off_q;
        funct3_d = funct3_q;
        read_d   = read_q;
        write_d  = write_q;
        mbe_d    = mbe_q;
        wdata_d  = wdata_q;
        mdr_d    = mdr_q;
        case (state_q)
            IDLE: begin
                if (mem_op && trap) begin
                    state_d = HOLD;
                end else if (mem_op) begin
                    addr_d   = {addr_in[31:2], 2'b00};
                    off_d    = off_eff;
                    funct3_d = funct3;
                    read_d   = mem_read;
                    write_d  = mem_write;
                    mbe_d    = mbe_new;
                    wdata_d  = rs2_in << {off_eff, 3'b000};
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                if (dmem_resp) begin
                    if (read_q) mdr_d = load_result;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (advance) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the datapath
    // registers are reset as well so the memory port reads all-zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            off_q    <= '0;
            funct3_q <= '0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            mbe_q    <= '0;
            wdata_q  <= '0;
            mdr_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            off_q    <= off_d;
            funct3_q <= funct3_d;
            read_q   <= read_d;
            write_q  <= write_d;
            mbe_q    <= mbe_d;
            wdata_q  <= wdata_d;
            mdr_q    <= mdr_d;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic misaligned_q, misaligned_d;

    always_comb begin
        misaligned_d = misaligned_q;
        if (state_q == IDLE && mem_op) misaligned_d = trap;
        else if (state_q == HOLD && advance) misaligned_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) misaligned_q <= 1'b0;
        else     misaligned_q <= misaligned_d;
    end

    assign misaligned = misaligned_q;
`endif

    // Stall depends only on state and the decoded op, never on advance.
    assign stall_out    = (state_q == ACCESS) || ((state_q == IDLE) && mem_op);
    assign dmem_address = addr_q;
    assign dmem_read    = read_q;
    assign dmem_write   = write_q;
    assign dmem_wdata   = wdata_q;
    assign dmem_mbe     = mbe_q;
    assign mdr_out      = mdr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage; expected load results go through a
// scoreboard queue. Covers both builds of MEM_MISALIGN_TRAP_EN.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr_in;
    logic [31:0] rs2_in;
    logic        advance;
    logic [31:0] dmem_address;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_mbe;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic [31:0] mdr_out;
    logic        stall_out;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];

    mem_stage dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .funct3       (funct3),
        .addr_in      (addr_in),
        .rs2_in       (rs2_in),
        .advance      (advance),
        .dmem_address (dmem_address),
        .dmem_read    (dmem_read),
        .dmem_write   (dmem_write),
        .dmem_wdata   (dmem_wdata),
        .dmem_mbe     (dmem_mbe),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp),
        .mdr_out      (mdr_out),
        .stall_out    (stall_out)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .misaligned   (misaligned)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'b000; addr_in = '0; rs2_in = '0;
        advance = 1'b1; dmem_resp = 1'b0; dmem_rdata = '0;
    endtask

    // One complete access: IDLE -> ACCESS (waits extra cycles) -> HOLD (hold_cycles with advance low) -> IDLE.
    task automatic do_access(input string name, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] rdata,
                             input int waits, input int hold_cycles,
                             input logic [31:0] exp_addr, input logic [3:0] exp_mbe,
                             input logic [31:0] exp_wdata, input logic [31:0] exp_mdr);
        logic [31:0] want;
        valid_in = 1'b1; mem_read = !wr; mem_write = wr;
        funct3 = f3; addr_in = addr; rs2_in = rs2; advance = 1'b0;
        if (!wr) exp_q.push_back(exp_mdr);
        #1;
        vectors++;
        if (stall_out !== 1'b1) begin miscompares++; $display("FAIL %s stall_idle: got %b want 1", name, stall_out); end
        step();
        for (int i = 0; i <= waits; i++) begin
            vectors++;
            if ({dmem_read, dmem_write, stall_out} !== {!wr, wr, 1'b1}) begin
                miscompares++;
                $display("FAIL %s strobes_cycle%0d: got rd=%b wr=%b stall=%b want rd=%b wr=%b stall=1",
                         name, i, dmem_read, dmem_write, stall_out, !wr, wr);
            end
            vectors++;
            if (dmem_address !== exp_addr) begin miscompares++; $display("FAIL %s address: got %h want %h", name, dmem_address, exp_addr); end
            if (wr || f3 == 3'b010) begin
                vectors++;
                if (dmem_mbe !== exp_mbe) begin miscompares++; $display("FAIL %s mbe: got %b want %b", name, dmem_mbe, exp_mbe); end
            end
            if (wr) begin
                vectors++;
                if (dmem_wdata !== exp_wdata) begin miscompares++; $display("FAIL %s wdata: got %h want %h", name, dmem_wdata, exp_wdata); end
            end
            if (i < waits) step();
        end
        dmem_resp = 1'b1; dmem_rdata = rdata;
        step();
        dmem_resp = 1'b0; dmem_rdata = ~rdata;
        want = mdr_out;
        if (!wr) want = exp_q.pop_front();
        for (int h = 0; h <= hold_cycles; h++) begin
            vectors++;
            if ({dmem_read, dmem_write, stall_out} !== 3'b000) begin
                miscompares++;
                $display("FAIL %s hold%0d_strobes: got rd=%b wr=%b stall=%b want 0 0 0", name, h, dmem_read, dmem_write, stall_out);
            end
            if (!wr) begin
                vectors++;
                if (mdr_out !== want) begin miscompares++; $display("FAIL %s hold%0d_mdr: got %h want %h", name, h, mdr_out, want); end
            end
            if (h < hold_cycles) begin
                dmem_resp = 1'b1;
                step();
                dmem_resp = 1'b0;
            end
        end
        advance = 1'b1;
        step();
        valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        #1;
        vectors++;
        if ({dmem_read, dmem_write, stall_out} !== 3'b000) begin
            miscompares++;
            $display("FAIL %s after_advance: got rd=%b wr=%b stall=%b want 0 0 0", name, dmem_read, dmem_write, stall_out);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        vectors++;
        if ({dmem_read, dmem_write, dmem_mbe} !== 6'b0) begin
            miscompares++; $display("FAIL reset_ctrl: got rd=%b wr=%b mbe=%b want 0", dmem_read, dmem_write, dmem_mbe);
        end
        vectors++;
        if ({dmem_address, dmem_wdata, mdr_out} !== 96'b0) begin
            miscompares++; $display("FAIL reset_data: got addr=%h wdata=%h mdr=%h want 0", dmem_address, dmem_wdata, mdr_out);
        end
        vectors++;
        if (stall_out !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b want 0", stall_out); end
`ifdef MEM_MISALIGN_TRAP_EN
        vectors++;
        if (misaligned !== 1'b0) begin miscompares++; $display("FAIL reset_misaligned: got %b want 0", misaligned); end
`endif
    endtask

    task automatic test_non_memory();
        logic [31:0] mdr_before;
        mdr_before = mdr_out;
        valid_in = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr_in = 32'h0000_0100;
        #1;
        vectors++;
        if (stall_out !== 1'b0) begin miscompares++; $display("FAIL nonmem_stall: got %b want 0", stall_out); end
        valid_in = 1'b0; mem_read = 1'b1;
        #1;
        vectors++;
        if (stall_out !== 1'b0) begin miscompares++; $display("FAIL invalid_stall: got %b want 0", stall_out); end
        dmem_resp = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        step(); step();
        dmem_resp = 1'b0; mem_read = 1'b0;
        vectors++;
        if ({dmem_read, dmem_write, mdr_out} !== {2'b00, mdr_before}) begin
            miscompares++; $display("FAIL idle_resp_ignored: got rd=%b wr=%b mdr=%h want 0 0 %h", dmem_read, dmem_write, mdr_out, mdr_before);
        end
    endtask

    task automatic test_loads();
        do_access("lw",       1'b0, 3'b010, 32'h1000_0004, '0, 32'hDEAD_BEEF, 0, 0, 32'h1000_0004, 4'b1111, '0, 32'hDEAD_BEEF);
        do_access("lb",       1'b0, 3'b000, 32'h2000_0003, '0, 32'h8012_3456, 0, 0, 32'h2000_0000, 4'b0000, '0, 32'hFFFF_FF80);
        do_access("lbu",      1'b0, 3'b100, 32'h2000_0003, '0, 32'h8012_3456, 0, 0, 32'h2000_0000, 4'b0000, '0, 32'h0000_0080);
        do_access("lb_pos",   1'b0, 3'b000, 32'h2000_0001, '0, 32'h8012_3456, 1, 0, 32'h2000_0000, 4'b0000, '0, 32'h0000_0034);
        do_access("lh",       1'b0, 3'b001, 32'h2000_0006, '0, 32'hBEEF_1234, 0, 0, 32'h2000_0004, 4'b0000, '0, 32'hFFFF_BEEF);
        do_access("lhu",      1'b0, 3'b101, 32'h2000_0006, '0, 32'hBEEF_1234, 2, 0, 32'h2000_0004, 4'b0000, '0, 32'h0000_BEEF);
        do_access("lh_pos",   1'b0, 3'b001, 32'h2000_0008, '0, 32'h8000_7FFF, 0, 0, 32'h2000_0008, 4'b0000, '0, 32'h0000_7FFF);
        do_access("ld_f3_110", 1'b0, 3'b110, 32'h0000_0010, '0, 32'h89AB_CDEF, 0, 0, 32'h0000_0010, 4'b0000, '0, 32'h89AB_CDEF);
    endtask

    task automatic test_stores();
        do_access("sh",       1'b1, 3'b001, 32'h3000_0002, 32'h0000_1234, '0, 3, 0, 32'h3000_0000, 4'b1100, 32'h1234_0000, '0);
        do_access("sb_off1",  1'b1, 3'b000, 32'h3000_0001, 32'h0000_00AB, '0, 0, 0, 32'h3000_0000, 4'b0010, 32'h0000_AB00, '0);
        do_access("sb_off3",  1'b1, 3'b000, 32'h3000_0003, 32'h1122_3344, '0, 0, 0, 32'h3000_0000, 4'b1000, 32'h4400_0000, '0);
        do_access("sw",       1'b1, 3'b010, 32'h3000_0008, 32'hCAFE_F00D, '0, 1, 0, 32'h3000_0008, 4'b1111, 32'hCAFE_F00D, '0);
        do_access("st_f3_111", 1'b1, 3'b111, 32'h3000_000C, 32'h0102_0304, '0, 0, 0, 32'h3000_000C, 4'b1111, 32'h0102_0304, '0);
    endtask

    task automatic test_hold_advance_low();
        do_access("hold_lw",  1'b0, 3'b010, 32'h4000_0000, '0, 32'h5555_AAAA, 0, 4, 32'h4000_0000, 4'b1111, '0, 32'h5555_AAAA);
    endtask

    task automatic test_back_to_back();
        do_access("b2b_sw",   1'b1, 3'b010, 32'h6000_0000, 32'h0BAD_CAFE, '0, 0, 0, 32'h6000_0000, 4'b1111, 32'h0BAD_CAFE, '0);
        do_access("b2b_lw",   1'b0, 3'b010, 32'h6000_0000, '0, 32'h0BAD_CAFE, 0, 0, 32'h6000_0000, 4'b1111, '0, 32'h0BAD_CAFE);
        do_access("b2b_lbu",  1'b0, 3'b100, 32'h6000_0002, '0, 32'h0BAD_CAFE, 0, 0, 32'h6000_0000, 4'b0000, '0, 32'h0000_00AD);
    endtask

    task automatic test_reset_mid_access();
        valid_in = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
        funct3 = 3'b010; addr_in = 32'h5000_0000; advance = 1'b0;
        step();
        vectors++;
        if (dmem_read !== 1'b1) begin miscompares++; $display("FAIL rst_mid_access_entry: got rd=%b want 1", dmem_read); end
        rst = 1'b1; dmem_resp = 1'b1; dmem_rdata = 32'h1234_5678;
        step();
        rst = 1'b0; dmem_resp = 1'b0;
        vectors++;
        if ({dmem_read, dmem_write, dmem_mbe, dmem_address} !== 38'b0) begin
            miscompares++; $display("FAIL rst_mid_access_port: got rd=%b wr=%b mbe=%b addr=%h want 0", dmem_read, dmem_write, dmem_mbe, dmem_address);
        end
        vectors++;
        if (mdr_out !== 32'h0) begin miscompares++; $display("FAIL rst_mid_access_mdr: got %h want 00000000", mdr_out); end
        vectors++;
        if (stall_out !== 1'b1) begin miscompares++; $display("FAIL rst_mid_access_idle: got stall=%b want 1", stall_out); end
        valid_in = 1'b0; mem_read = 1'b0; advance = 1'b1;
        step();
    endtask

    task automatic test_misaligned();
`ifdef MEM_MISALIGN_TRAP_EN
        valid_in = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
        funct3 = 3'b010; addr_in = 32'h4000_0001; advance = 1'b0;
        #1;
        vectors++;
        if (stall_out !== 1'b1) begin miscompares++; $display("FAIL trap_idle_stall: got %b want 1", stall_out); end
        step();
        vectors++;
        if ({dmem_read, dmem_write, misaligned, stall_out} !== 4'b0010) begin
            miscompares++; $display("FAIL trap_lw: got rd=%b wr=%b mis=%b stall=%b want 0 0 1 0", dmem_read, dmem_write, misaligned, stall_out);
        end
        advance = 1'b1;
        step();
        valid_in = 1'b0; mem_read = 1'b0;
        vectors++;
        if (misaligned !== 1'b0) begin miscompares++; $display("FAIL trap_clear: got %b want 0", misaligned); end
        valid_in = 1'b1; mem_write = 1'b1; funct3 = 3'b001; addr_in = 32'h4000_0003; advance = 1'b0;
        step();
        vectors++;
        if ({dmem_read, dmem_write, misaligned, stall_out} !== 4'b0010) begin
            miscompares++; $display("FAIL trap_sh: got rd=%b wr=%b mis=%b stall=%b want 0 0 1 0", dmem_read, dmem_write, misaligned, stall_out);
        end
        advance = 1'b1;
        step();
        valid_in = 1'b0; mem_write = 1'b0;
        do_access("trap_sb_ok", 1'b1, 3'b000, 32'h4000_0003, 32'h0000_00C3, '0, 0, 0, 32'h4000_0000, 4'b1000, 32'hC300_0000, '0);
`else
        do_access("mis_lw",   1'b0, 3'b010, 32'h4000_0001, '0, 32'h1122_3344, 0, 0, 32'h4000_0000, 4'b1111, '0, 32'h1122_3344);
        do_access("mis_sh",   1'b1, 3'b001, 32'h4000_0003, 32'h0000_BEEF, '0, 0, 0, 32'h4000_0000, 4'b1100, 32'hBEEF_0000, '0);
        do_access("mis_lh",   1'b0, 3'b001, 32'h4000_0001, '0, 32'h0000_8001, 0, 0, 32'h4000_0000, 4'b0000, '0, 32'hFFFF_8001);
        do_access("mis_sw",   1'b1, 3'b010, 32'h4000_0006, 32'h0000_00FF, '0, 0, 0, 32'h4000_0004, 4'b1111, 32'h0000_00FF, '0);
`endif
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_non_memory();
        test_loads();
        test_stores();
        test_hold_advance_low();
        test_back_to_back();
        test_reset_mid_access();
        test_misaligned();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage controller for the pipelined RV32I core, sitting between the EX/MEM pipeline register and the MEM/WB register. It issues loads and stores to the data memory port with byte-lane steering, and holds the pipeline until the response returns. It then presents sign/zero-extended load data on `mdr_out`, which feeds the MEM/WB register's `mdr_in`. Non-memory instructions pass through with no stall.

## Interface
Parameters: none.

Ports:
- `clk` — input, 1 — single clock; all state changes on its rising edge.
- `rst` — input, 1 — synchronous, active-high reset.
- `valid_in` — input, 1 — EX/MEM holds a live instruction.
- `mem_read` / `mem_write` — input, 1 each — from the EX/MEM control word; never both high.
- `funct3` — input, 3 — access size and sign.
- `addr_in` — input, 32 — ALU result, the byte address.
- `rs2_in` — input, 32 — store data.
- `advance` — input, 1 — global pipeline-advance (load enable of EX/MEM and MEM/WB), high when no stage stalls.
- `dmem_address` — output, 32 — word-aligned address.
- `dmem_read` / `dmem_write` — output, 1 each — request strobes.
- `dmem_wdata` — output, 32 — lane-shifted store data.
- `dmem_mbe` — output, 4 — byte enables.
- `dmem_rdata` — input, 32 — read data.
- `dmem_resp` — input, 1 — one-cycle completion pulse.
- `mdr_out` — output, 32 — aligned load result.
- `stall_out` — output, 1 — combinational; forces `advance` low.
- `misaligned` — output, 1 — present only with `MEM_MISALIGN_TRAP_EN`.

## Operation
- The FSM has three states: IDLE, ACCESS and HOLD.
- **IDLE**
  - A memory op is `valid_in` with `mem_read` or `mem_write` high.
  - On a memory op, capture the following into request registers:
    - `{addr_in[31:2],2'b00}`
    - offset `addr_in[1:0]`
    - `funct3`
    - read/write
    - `dmem_mbe`
    - `dmem_wdata`
  - Then go to ACCESS.
  - `stall_out` = memory op present.
- **ACCESS**
  - `dmem_read` or `dmem_write` is held high with stable address, data and mbe until `dmem_resp`. `stall_out`=1.
  - On `dmem_resp`:
    - For a read, register the aligned `dmem_rdata` into `mdr_out`.
    - Drop the strobes the next cycle.
    - Go to HOLD.
- **HOLD**
  - `stall_out`=0. `mdr_out` is held.
  - If `advance`=1, go to IDLE; otherwise stay.
  - A memory op in EX/MEM during HOLD is the same instruction, so HOLD never re-issues.
- **Stores**, by `funct3` (000 sb, 001 sh, 010 sw):
  - sb: mbe `4'b0001<<off`; wdata `rs2<<(8*off)`.
  - sh: mbe `4'b0011<<off`; wdata `rs2<<(8*off)`.
  - sw: mbe `4'b1111`; wdata `rs2<<(8*off)`.
  - Any other `funct3` is treated as sw.
- **Loads**: the byte/half is selected by the captured offset.
  - 000 lb: sign-extended byte.
  - 100 lbu: zero-extended byte.
  - 001 lh: sign-extended half.
  - 101 lhu: zero-extended half.
  - 010 lw, and any other `funct3`: full word.
- Non-memory or `valid_in`=0 instructions:
  - No request, `stall_out`=0, `mdr_out` unchanged.
- Boundary behaviour:
  - `dmem_resp` is ignored outside ACCESS.
  - Reset in any state returns to IDLE and takes precedence over a same-cycle `dmem_resp`.

## Timing
- Reset values:
  - state IDLE.
  - `dmem_read`, `dmem_write`, `dmem_mbe`, `dmem_address`, `dmem_wdata` all 0.
  - `mdr_out` 0.
  - `misaligned` 0.
- Example with the op first seen at cycle 0 and a zero-wait memory:
  - Cycle 0: the op is first seen in IDLE; `stall_out`=1.
  - Cycle 1: strobes are high in ACCESS; `dmem_resp` can arrive this cycle.
  - Cycle 2: HOLD; `mdr_out` is valid; `stall_out`=0.
  - Minimum stall is 2 cycles; each memory wait cycle adds one.
- `stall_out` depends only on state, `valid_in`, `mem_read` and `mem_write`. It never depends on `advance`, so there is no combinational loop.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - A lw with offset≠0, or an lh/lhu/sh with `off[0]`=1, issues no request and goes straight to HOLD.
  - `misaligned`=1 while in that HOLD; `stall_out`=0.
- `MEM_MISALIGN_TRAP_EN` undefined:
  - No `misaligned` port.
  - Offending low bits are masked: word accesses use `off`=0 and half accesses use `off[0]`=0. The access then proceeds normally.

## Structure
- Package `rv32i_types` holds:
  - the `load_funct3_t` (lb, lh, lw, lbu, lhu) and `store_funct3_t` (sb, sh, sw) enums;
  - the `mem_stage_state_t` enum (IDLE, ACCESS, HOLD).
- One combinational sub-module, `load_align`, takes rdata, offset and funct3 and produces the 32-bit result. A bench can reuse it as the reference model.

## Test plan
- **lw**: `addr_in`=0x1000_0004 → `dmem_address`=0x1000_0004, mbe=1111. `dmem_resp` with rdata 0xDEAD_BEEF → `mdr_out`=0xDEAD_BEEF in HOLD.
- **lb / lbu**: lb at 0x…03, rdata 0x80xx_xxxx → `mdr_out`=0xFFFF_FF80. lbu at the same address → 0x0000_0080.
- **sh**: `addr_in`=0x…02, rs2=0x0000_1234 → mbe=1100, wdata=0x1234_0000, `dmem_write` held through 3 wait cycles with `stall_out`=1.
- **advance low in HOLD**: hold `advance`=0 for 4 cycles → state stays HOLD, no second request, `mdr_out` stable.
- **Reset mid-ACCESS**: assert `rst` in the same cycle as `dmem_resp` → next cycle IDLE, strobes 0, `mdr_out`=0.
- **Misaligned lw at 0x…01**:
  - With `MEM_MISALIGN_TRAP_EN`: no strobe, `misaligned`=1.
  - Without it: `dmem_address`=0x…00, mbe=1111.
